mem_rw_port_arb: RTL

MEM_RW_PORT_ARB -- requirements
Module: mem_rw_port_arb

---
 rtl/mem_rw_port_arb_pkg.sv | 22 ++
 rtl/mem_rw_port_arb_rr_arb_pick.sv | 23 ++
 rtl/mem_rw_port_arb.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_rw_port_arb_pkg.sv
// mem_rw_port_arb_pkg: shared types and parameter range checks for the memory RW port arbiter
package mem_rw_port_arb_pkg;

   localparam int MAX_NREQ = 8;
   localparam int IDX_W    = 3;

   typedef logic [IDX_W-1:0] rr_idx_t;

   typedef struct packed {
      logic    valid;
      rr_idx_t idx;
   } tag_t;

   function automatic bit nreq_ok(input int n);
      return (n >= 2) && (n <= MAX_NREQ);
   endfunction

   function automatic bit latency_ok(input int l);
      return l >= 1;
   endfunction

endpackage

// File: rtl/mem_rw_port_arb_rr_arb_pick.sv
// rr_arb_pick: one-hot pick of the first active requester at or after the pointer, wrapping
module rr_arb_pick
   import mem_rw_port_arb_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] i_req,
   input  rr_idx_t         i_ptr,
   output logic [NREQ-1:0] o_gnt
);

   logic [NREQ-1:0] w_hi;
   logic [NREQ-1:0] w_sel;

   // lowest request at/above the pointer wins; if none, wrap to the lowest request overall
   always_comb begin
      w_hi = '0;
      for (int i = 0; i < NREQ; i++) w_hi[i] = i_req[i] && (i >= int'(i_ptr));
      w_sel = (|w_hi) ? w_hi : i_req;
      o_gnt = w_sel & (~w_sel + NREQ'(1));
   end

endmodule

// File: rtl/mem_rw_port_arb.sv
// mem_rw_port_arb: round-robin sharing of one memory RW port with tagged read-response routing
module mem_rw_port_arb
   import mem_rw_port_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int AW      = 13,
   parameter int DW      = 32,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req_read,
   input  logic [NREQ-1:0]  req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_din,
   output logic [NREQ-1:0]  req_gnt,
   input  logic             ready,
   input  logic             refr,
   output logic             mem_read,
   output logic             mem_write,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_din,
   input  logic [DW-1:0]    mem_dout,
   input  logic             mem_read_vld,
   input  logic             mem_read_serr,
   input  logic             mem_read_derr,
   output logic [NREQ-1:0]  rsp_vld,
   output logic [DW-1:0]    rsp_dout,
   output logic             rsp_serr,
   output logic             rsp_derr,
   output logic             err_illegal,
   output logic             err_vld_mismatch
);

   if (!nreq_ok(NREQ) || !latency_ok(LATENCY)) begin : g_bad_param
      $error("mem_rw_port_arb: NREQ must be 2..8 and LATENCY >= 1");
   end

   logic [NREQ-1:0] w_act;
   logic [NREQ-1:0] w_pick;
   logic            w_any;
   rr_idx_t         w_idx;
   logic            w_rd;
   logic            w_wr;
   logic [AW-1:0]   w_addr;
   logic [DW-1:0]   w_din;
   tag_t            w_head;
   logic            w_rvld;
   rr_idx_t         r_ptr;
   tag_t            r_tag [LATENCY+1];
   logic [DW-1:0]   r_dout;

   assign w_act = req_read | req_write;

   rr_arb_pick #(.NREQ(NREQ)) u_pick (
      .i_req(w_act),
      .i_ptr(r_ptr),
      .o_gnt(w_pick)
   );

   assign req_gnt = (ready && !refr && !rst) ? w_pick : '0;
   assign w_any   = |req_gnt;

   // encode the granted index and mux that requester's command fields
   always_comb begin
      w_idx  = '0;
      w_rd   = 1'b0;
      w_wr   = 1'b0;
      w_addr = '0;
      w_din  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_gnt[i]) begin
            w_idx  = rr_idx_t'(i);
            w_rd   = req_read[i];
            w_wr   = req_write[i];
            w_addr = req_addr[i*AW +: AW];
            w_din  = req_din[i*DW +: DW];
         end
      end
   end

   // memory command register, pointer advance, read-tag pipeline and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr            <= '0;
         mem_read         <= 1'b0;
         mem_write        <= 1'b0;
         mem_addr         <= '0;
         mem_din          <= '0;
         r_dout           <= '0;
         err_illegal      <= 1'b0;
         err_vld_mismatch <= 1'b0;
         for (int k = 0; k <= LATENCY; k++) r_tag[k] <= '0;
      end else begin
         mem_read  <= w_any && w_rd && !w_wr;
         mem_write <= w_any && w_wr;
         if (w_any) begin
            r_ptr    <= (w_idx == rr_idx_t'(NREQ-1)) ? '0 : w_idx + rr_idx_t'(1);
            mem_addr <= w_addr;
            mem_din  <= w_din;
         end
         r_tag[0] <= '{valid: w_any && w_rd && !w_wr, idx: w_idx};
         for (int k = 1; k <= LATENCY; k++) r_tag[k] <= r_tag[k-1];
         if (w_rvld) r_dout <= mem_dout;
         if (w_any && w_rd && w_wr) err_illegal <= 1'b1;
         if (mem_read_vld != w_head.valid) err_vld_mismatch <= 1'b1;
      end
   end

   assign w_head   = r_tag[LATENCY];
   assign w_rvld   = w_head.valid && !rst;
   assign rsp_vld  = w_rvld ? (NREQ'(1) << w_head.idx) : '0;
   assign rsp_dout = w_rvld ? mem_dout : r_dout;
   assign rsp_serr = w_rvld && mem_read_serr;
   assign rsp_derr = w_rvld && mem_read_derr;

endmodule
